// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter (baud divisor, 5-9 data bits, parity, 1/2 stop bits).
// Optional flow control: define UART_TX_CTS_EN to add the synchronised i_cts_n input.
module uart_tx_cfg #(
    parameter int DIV_W         = 16,
    parameter int MAX_DATA_BITS = 9
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_valid,
    input  logic [MAX_DATA_BITS-1:0] i_data,
    output logic                     o_ready,
    input  logic [DIV_W-1:0]         i_baud_div,
    input  logic [3:0]               i_data_bits,
    input  logic                     i_parity_en,
    input  logic                     i_parity_odd,
    input  logic                     i_stop2,
`ifdef UART_TX_CTS_EN
    input  logic                     i_cts_n,
`endif
    output logic                     o_tx,
    output logic                     o_busy,
    output logic                     o_done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                   state, state_n;
    logic [DIV_W-1:0]         timer, timer_n;
    logic [3:0]               bit_idx, bit_idx_n;
    logic                     stop_cnt, stop_cnt_n;
    logic [MAX_DATA_BITS-1:0] data_reg, data_masked;
    logic [DIV_W-1:0]         div_reg, div_c;
    logic [3:0]               nbits_reg, nbits_c;
    logic                     par_en_reg, par_odd_reg, stop2_reg;
    logic                     parity_bit, bit_end, transfer, cts_ok;
    logic                     tx_d, done_d;

`ifdef UART_TX_CTS_EN
    logic cts_meta, cts_sync;

    // Synchroniser resets to "not clear" so nothing is accepted until CTS is seen low.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cts_meta <= 1'b1;
            cts_sync <= 1'b1;
        end else begin
            cts_meta <= i_cts_n;
            cts_sync <= cts_meta;
        end
    end

    assign cts_ok = ~cts_sync;
`else
    assign cts_ok = 1'b1;
`endif

    assign div_c    = (i_baud_div < DIV_W'(2)) ? DIV_W'(2) : i_baud_div;
    assign nbits_c  = (i_data_bits < 4'd5) ? 4'd5 :
                      (i_data_bits > 4'd9) ? 4'd9 : i_data_bits;
    assign transfer = i_valid && o_ready;
    assign bit_end  = (timer == div_reg - DIV_W'(1));

    // Unused upper data bits are cleared at latch time so parity is a plain XOR.
    assign parity_bit = (^data_reg) ^ par_odd_reg;

    always_comb begin
        data_masked = '0;
        for (int i = 0; i < MAX_DATA_BITS; i++) begin
            if (i < int'(nbits_c)) data_masked[i] = i_data[i];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            timer       <= '0;
            bit_idx     <= '0;
            stop_cnt    <= 1'b0;
            o_tx        <= 1'b1;
            o_done      <= 1'b0;
            data_reg    <= '0;
            div_reg     <= '0;
            nbits_reg   <= '0;
            par_en_reg  <= 1'b0;
            par_odd_reg <= 1'b0;
            stop2_reg   <= 1'b0;
        end else begin
            state    <= state_n;
            timer    <= timer_n;
            bit_idx  <= bit_idx_n;
            stop_cnt <= stop_cnt_n;
            o_tx     <= tx_d;
            o_done   <= done_d;
            if (transfer) begin
                data_reg    <= data_masked;
                div_reg     <= div_c;
                nbits_reg   <= nbits_c;
                par_en_reg  <= i_parity_en;
                par_odd_reg <= i_parity_odd;
                stop2_reg   <= i_stop2;
            end
        end
    end

    always_comb begin
        state_n    = state;
        timer_n    = bit_end ? '0 : timer + DIV_W'(1);
        bit_idx_n  = bit_idx;
        stop_cnt_n = stop_cnt;
        case (state)
            IDLE: begin
                timer_n = '0;
                if (transfer) begin
                    state_n    = START;
                    bit_idx_n  = '0;
                    stop_cnt_n = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n   = DATA;
                    bit_idx_n = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == nbits_reg - 4'd1) begin
                        state_n    = par_en_reg ? PARITY : STOP;
                        stop_cnt_n = 1'b0;
                    end else begin
                        bit_idx_n = bit_idx + 4'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_n    = STOP;
                    stop_cnt_n = 1'b0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (stop2_reg && !stop_cnt) begin
                        stop_cnt_n = 1'b1;
                    end else begin
                        state_n    = IDLE;
                        stop_cnt_n = 1'b0;
                    end
                end
            end
            default: begin
                state_n    = IDLE;
                timer_n    = '0;
                bit_idx_n  = '0;
                stop_cnt_n = 1'b0;
            end
        endcase
    end

    // The line level is computed from the next state so o_tx can be a flop.
    always_comb begin
        tx_d = 1'b1;
        case (state_n)
            START:   tx_d = 1'b0;
            DATA:    tx_d = data_reg[bit_idx_n];
            PARITY:  tx_d = parity_bit;
            default: tx_d = 1'b1;
        endcase
        done_d  = (state == STOP) && (state_n == IDLE);
        o_busy  = (state != IDLE);
        o_ready = (state == IDLE) && cts_ok;
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: expected line levels come from a frame model
// built from the clamped configuration (start, data LSB first, parity, stops).
module tb_uart_tx_cfg;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b1;
    logic        i_valid;
    logic [8:0]  i_data;
    logic        o_ready;
    logic [15:0] i_baud_div;
    logic [3:0]  i_data_bits;
    logic        i_parity_en;
    logic        i_parity_odd;
    logic        i_stop2;
    logic        o_tx;
    logic        o_busy;
    logic        o_done;
`ifdef UART_TX_CTS_EN
    logic        i_cts_n;
    localparam bit HAS_CTS = 1'b1;
`else
    localparam bit HAS_CTS = 1'b0;
`endif

    int total = 0;
    int bad   = 0;
    int cts_raise_at = 0;

    always #5 i_clk = ~i_clk;

    uart_tx_cfg #(.DIV_W(16), .MAX_DATA_BITS(9)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_valid      (i_valid),
        .i_data       (i_data),
        .o_ready      (o_ready),
        .i_baud_div   (i_baud_div),
        .i_data_bits  (i_data_bits),
        .i_parity_en  (i_parity_en),
        .i_parity_odd (i_parity_odd),
        .i_stop2      (i_stop2),
`ifdef UART_TX_CTS_EN
        .i_cts_n      (i_cts_n),
`endif
        .o_tx         (o_tx),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    // Sends one word and checks every line cycle against the model; called at a negedge.
    task automatic run_frame(input string name, input logic [8:0] data, input int div_in,
                             input int bits_in, input bit par, input bit odd, input bit stop2,
                             input bit hold, input bit expect_now, input int abort_at);
        int dv, nb, len, waits;
        bit q[$];
        bit p;
        bit exp_ready;
        dv = (div_in < 2) ? 2 : div_in;
        nb = (bits_in < 5) ? 5 : ((bits_in > 9) ? 9 : bits_in);
        q.push_back(1'b0);
        p = odd;
        for (int i = 0; i < nb; i++) begin
            q.push_back(data[i]);
            p = p ^ data[i];
        end
        if (par) q.push_back(p);
        q.push_back(1'b1);
        if (stop2) q.push_back(1'b1);
        len = dv * q.size();

        i_data       = data;
        i_baud_div   = 16'(div_in);
        i_data_bits  = 4'(bits_in);
        i_parity_en  = par;
        i_parity_odd = odd;
        i_stop2      = stop2;
        i_valid      = 1'b1;
        waits = 0;
        while (!o_ready && waits < 200) begin
            @(negedge i_clk);
            waits++;
        end
        total++;
        if (!o_ready || (expect_now && waits != 0)) begin
            bad++;
            $display("[TB] FAIL %s accept: ready=%0b idle_waits=%0d, required ready=1 idle_waits=%0s",
                     name, o_ready, waits, expect_now ? "0" : "<200");
        end
        if (!o_ready) begin
            i_valid = 1'b0;
            return;
        end
        @(negedge i_clk);

        for (int k = 1; k <= len; k++) begin
            total++;
            if (o_tx !== q[(k-1)/dv] || o_busy !== 1'b1 || o_done !== 1'b0) begin
                bad++;
                $display("[TB] FAIL %s cycle %0d: tx=%b busy=%b done=%b, required tx=%b busy=1 done=0",
                         name, k, o_tx, o_busy, o_done, q[(k-1)/dv]);
            end
            if (!hold) i_valid = 1'b0;
            i_data       = 9'($urandom);
            i_baud_div   = 16'($urandom_range(0, 7));
            i_data_bits  = 4'($urandom);
            i_parity_en  = 1'($urandom);
            i_parity_odd = 1'($urandom);
            i_stop2      = 1'($urandom);
`ifdef UART_TX_CTS_EN
            if (k == cts_raise_at) i_cts_n = 1'b1;
`endif
            if (k == abort_at) return;
            @(negedge i_clk);
        end

        exp_ready = 1'b1;
`ifdef UART_TX_CTS_EN
        exp_ready = !i_cts_n;
`endif
        total++;
        if (o_done !== 1'b1 || o_tx !== 1'b1 || o_busy !== 1'b0 || o_ready !== exp_ready) begin
            bad++;
            $display("[TB] FAIL %s end: done=%b tx=%b busy=%b ready=%b, required done=1 tx=1 busy=0 ready=%b",
                     name, o_done, o_tx, o_busy, o_ready, exp_ready);
        end
        if (!hold) begin
            @(negedge i_clk);
            total++;
            if (o_done !== 1'b0 || o_busy !== 1'b0 || o_tx !== 1'b1) begin
                bad++;
                $display("[TB] FAIL %s after: done=%b busy=%b tx=%b, required done=0 busy=0 tx=1",
                         name, o_done, o_busy, o_tx);
            end
        end
    endtask

    task automatic test_reset();
        i_valid = 1'b0; i_data = '0; i_baud_div = 16'd4; i_data_bits = 4'd8;
        i_parity_en = 1'b0; i_parity_odd = 1'b0; i_stop2 = 1'b0;
`ifdef UART_TX_CTS_EN
        i_cts_n = 1'b0;
`endif
        #1 i_rst_n = 1'b0;
        repeat (3) @(negedge i_clk);
        total++;
        if (o_tx !== 1'b1) begin bad++; $display("[TB] FAIL reset_tx: got %b, required 1", o_tx); end
        total++;
        if (o_busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b, required 0", o_busy); end
        total++;
        if (o_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done: got %b, required 0", o_done); end
        total++;
        if (o_ready !== !HAS_CTS) begin
            bad++; $display("[TB] FAIL reset_ready: got %b, required %b", o_ready, !HAS_CTS);
        end
        i_rst_n = 1'b1;
        repeat (3) @(negedge i_clk);
    endtask

    task automatic test_directed();
        run_frame("8N1_A5",  9'h0A5, 4, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        run_frame("7E2_1C1", 9'h1C1, 3, 7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        run_frame("9O1_1FF", 9'h1FF, 2, 9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        run_frame("clamp_low", 9'h0B6, 0, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        run_frame("clamp_high", 9'h15A, 1, 14, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        run_frame("b2b_first",  9'h03C, 5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
        run_frame("b2b_second", 9'h0C3, 5, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    endtask

    task automatic test_mid_frame_reset();
        // Cycle 18 of a div=4 frame lies inside data bit 3.
        run_frame("abort", 9'h0F3, 4, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 18);
        #2 i_rst_n = 1'b0;
        #1;
        total++;
        if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL abort_reset: tx=%b busy=%b done=%b, required tx=1 busy=0 done=0",
                     o_tx, o_busy, o_done);
        end
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            total++;
            if (o_done !== 1'b0 || o_tx !== 1'b1 || o_busy !== 1'b0) begin
                bad++;
                $display("[TB] FAIL abort_quiet %0d: done=%b tx=%b busy=%b, required done=0 tx=1 busy=0",
                         k, o_done, o_tx, o_busy);
            end
        end
        run_frame("after_abort", 9'h05D, 3, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_random();
        bit prev_hold = 1'b0;
        bit hold;
        for (int i = 0; i < 30; i++) begin
            hold = (i < 29) ? 1'($urandom) : 1'b0;
            run_frame($sformatf("rand%0d", i), 9'($urandom), int'($urandom_range(0, 6)),
                      int'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 1'($urandom),
                      hold, prev_hold, 0);
            prev_hold = hold;
        end
    endtask

`ifdef UART_TX_CTS_EN
    task automatic test_cts();
        cts_raise_at = 10;
        run_frame("cts_frame", 9'h0A9, 3, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        cts_raise_at = 0;
        i_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            total++;
            if (o_ready !== 1'b0 || o_busy !== 1'b0) begin
                bad++; $display("[TB] FAIL cts_blocked %0d: ready=%b busy=%b, required 0 0", k, o_ready, o_busy);
            end
        end
        i_valid = 1'b0;
        i_cts_n = 1'b0;
        @(negedge i_clk);
        total++;
        if (o_ready !== 1'b0) begin bad++; $display("[TB] FAIL cts_lag1: ready=%b, required 0", o_ready); end
        @(negedge i_clk);
        total++;
        if (o_ready !== 1'b1) begin bad++; $display("[TB] FAIL cts_lag2: ready=%b, required 1", o_ready); end
    endtask
`endif

    initial begin
        $display("[TB] uart_tx_cfg bench start");
        test_reset();
        test_directed();
        test_back_to_back();
        test_mid_frame_reset();
        test_random();
`ifdef UART_TX_CTS_EN
        test_cts();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Runtime-configurable UART transmitter: serialises words from a valid/ready source onto `o_tx`, with baud divisor, data width (5–9), parity mode and stop-bit count selectable per frame through configuration ports rather than fixed at elaboration. It sits between the result/command FIFO read side and the board TX pin, and is the drop-in generalisation of the fixed-format transmitter for links whose format is set by host software.

## Interface
- `DIV_W`, 16: width of the baud divisor port.
- `MAX_DATA_BITS`, 9: width of `i_data`; fixed at 9, and the supported range is 5–9.
- `i_clk`  in  1  system clock.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_valid`  in  1  source has a word on `i_data`.
- `i_data`  in  9  word to send, LSB first; bits at and above `i_data_bits` are ignored.
- `o_ready`  out  1  transmitter accepts a word this cycle.
- `i_baud_div`  in  DIV_W  clocks per bit; values below 2 are treated as 2.
- `i_data_bits`  in  4  data bits per frame; below 5 treated as 5, above 9 treated as 9.
- `i_parity_en`  in  1  1 = parity bit appended.
- `i_parity_odd`  in  1  0 = even parity, 1 = odd parity.
- `i_stop2`  in  1  0 = one stop bit, 1 = two stop bits.
- `i_cts_n`  in  1  clear-to-send, active-low; present only with `UART_TX_CTS_EN`.
- `o_tx`  out  1  serial line, idle high.
- `o_busy`  out  1  frame in progress.
- `o_done`  out  1  one-cycle pulse at frame end.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Reset values: `o_tx`=1, `o_busy`=0, `o_done`=0, state IDLE, all counters 0. `o_ready`=1, or follows CTS when `UART_TX_CTS_EN` is defined.
- `o_ready` = (state==IDLE), additionally gated by synchronised CTS. Transfer occurs when `i_valid && o_ready`.
- On transfer, the block latches `i_data` and the clamped config (`div`, `nbits`, `par_en`, `par_odd`, `stop2`) in the same edge and moves to START. Config changes after that have no effect until the next transfer.
- Bit timer counts 0..div-1. Every bit, including each stop bit, is held for exactly `div` clocks.
- START drives 0 → DATA. DATA shifts out bits 0..nbits-1, using a 4-bit index.
- After the last data bit, the block goes to PARITY if `par_en`, else STOP.
  - Even parity bit = XOR of the `nbits` data bits.
  - Odd parity bit = its inverse.
- STOP drives 1 for 1 or 2 bit times, then returns to IDLE.
- `o_done` pulses on the edge where the state returns to IDLE. `o_busy` is high in every non-IDLE state.
- Any state encoding outside the defined set returns to IDLE with reset values.
- Reset asserted mid-frame takes effect immediately. The frame is truncated, `o_tx` goes to 1, and there is no `o_done`.

## Timing
- Start bit appears on `o_tx` the cycle after the transfer edge.
- Frame length = div × (1 + nbits + par_en + 1 + stop2) clocks. `o_done` is asserted in the cycle after the final stop-bit clock.
- Back-to-back frames with `i_valid` held: exactly one IDLE cycle (`o_tx`=1, `o_ready`=1) between the end of the last stop bit and the next transfer. The next start bit follows one cycle after that.
- `o_tx` is registered, with no combinational path from any input.

## Configuration
- `UART_TX_CTS_EN` defined:
  - `i_cts_n` exists and is synchronised through two flops.
  - `o_ready` = IDLE && synchronised cts_n==0.
  - Deasserting CTS never aborts or stretches a frame in progress; it only blocks the next transfer.
  - Reset value of the synchroniser is 1 (not clear), so `o_ready`=0 until CTS has been low for 2 clocks.
- Undefined: the port is absent and `o_ready` = IDLE.

## Test plan
- div=4, 8N1, send 0xA5 → `o_tx` sequence 0,1,0,1,0,0,1,0,1,1, each held 4 clocks. `o_done` fires 40 clocks after the start bit begins.
- div=3, 7 bits, even parity, 2 stop bits, data 0x1C1 → data bits 1,0,0,0,0,0,1 (upper bits ignored), parity 0, stop 1,1. Frame = 33 clocks.
- div=2, 9 bits, odd parity, data 0x1FF → nine 1s, then parity 0. Separately, `i_data_bits`=3 and `i_baud_div`=0 → behaves as 5 bits at div=2.
- Two words with `i_valid` held, div=5, 8N1 → exactly one idle-high clock between the end of the first stop bit and the accept of the second word. Changing `i_data_bits` mid-frame leaves the current frame unchanged.
- Reset pulsed during DATA bit 3 → `o_tx`=1 and `o_busy`=0 immediately, no `o_done`. The next word is sent cleanly after reset is released.
- `UART_TX_CTS_EN`: `i_cts_n` raised mid-frame → frame completes and `o_ready` stays 0. Lowering it → `o_ready` rises 2 clocks later.
